// File: rtl/bp_me_pkg.sv
// Shared types for the CCE-MEM burst memory responder: processor config, BedRock header,
// FSM states and burst helpers. The e_reset state exists only with BP_ME_BURST_MEM_RESPONDER_ZERO_INIT_EN.
package bp_me_pkg;

  typedef enum logic [0:0] {e_bp_default_cfg = 1'b0} bp_params_e;

  typedef struct packed {
    int paddr_width;
    int dword_width;
    int cce_block_width;
    int lce_id_width;
    int lce_assoc;
  } bp_proc_param_s;

  localparam bp_proc_param_s bp_default_cfg_gp = '{
    paddr_width:     40,
    dword_width:     64,
    cce_block_width: 512,
    lce_id_width:    8,
    lce_assoc:       8
  };

  function automatic bp_proc_param_s bp_get_params(input bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return bp_default_cfg_gp;
      default:          return bp_default_cfg_gp;
    endcase
  endfunction

  localparam int paddr_width_gp   = bp_default_cfg_gp.paddr_width;
  localparam int lce_id_width_gp  = bp_default_cfg_gp.lce_id_width;
  localparam int way_id_width_gp  = $clog2(bp_default_cfg_gp.lce_assoc);

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'd0,
    e_bedrock_mem_wr    = 4'd1,
    e_bedrock_mem_uc_rd = 4'd2,
    e_bedrock_mem_uc_wr = 4'd3,
    e_bedrock_mem_pre   = 4'd4,
    e_bedrock_mem_amo   = 4'd5
  } bp_bedrock_mem_type_e;

  typedef enum logic [2:0] {
    e_bedrock_msg_size_1   = 3'd0,
    e_bedrock_msg_size_2   = 3'd1,
    e_bedrock_msg_size_4   = 3'd2,
    e_bedrock_msg_size_8   = 3'd3,
    e_bedrock_msg_size_16  = 3'd4,
    e_bedrock_msg_size_32  = 3'd5,
    e_bedrock_msg_size_64  = 3'd6,
    e_bedrock_msg_size_128 = 3'd7
  } bp_bedrock_msg_size_e;

  typedef struct packed {
    logic [lce_id_width_gp-1:0] lce_id;
    logic [way_id_width_gp-1:0] way_id;
  } bp_bedrock_cce_mem_payload_s;

  typedef struct packed {
    bp_bedrock_cce_mem_payload_s payload;
    bp_bedrock_msg_size_e        size;
    logic [paddr_width_gp-1:0]   addr;
    bp_bedrock_mem_type_e        msg_type;
  } bp_bedrock_cce_mem_header_s;

  localparam int cce_mem_msg_header_width_gp = $bits(bp_bedrock_cce_mem_header_s);

  typedef enum logic [2:0] {
    e_ready     = 3'd0,
    e_write     = 3'd1,
    e_write_hdr = 3'd2,
    e_read_hdr  = 3'd3,
    e_read_data = 3'd4
`ifdef BP_ME_BURST_MEM_RESPONDER_ZERO_INIT_EN
    , e_reset   = 3'd5
`endif
  } bp_me_burst_mem_resp_state_e;

  // Size is log2 of the byte count; a burst never has fewer than one beat.
  function automatic logic [4:0] bp_me_burst_beats(input logic [2:0] size, input int dword_width);
    int n;
    n = int'(32'd8 << size) / dword_width;
    if (n < 32'sd1) begin
      n = 32'sd1;
    end else begin
      n = n;
    end
    return n[4:0];
  endfunction

  function automatic logic [7:0] bp_me_byte_mask(input logic [2:0] size, input logic [2:0] offset);
    logic [7:0] m;
    if (size < 3'd3) begin
      m = ((8'd1 << (4'd1 << size)) - 8'd1) << offset;
    end else begin
      m = 8'hFF;
    end
    return m;
  endfunction

  function automatic logic bp_me_is_read(input bp_bedrock_mem_type_e t);
    return (t == e_bedrock_mem_rd) || (t == e_bedrock_mem_uc_rd);
  endfunction

  function automatic logic bp_me_is_write(input bp_bedrock_mem_type_e t);
    return (t == e_bedrock_mem_wr) || (t == e_bedrock_mem_uc_wr);
  endfunction

endpackage

// File: rtl/bsg_mem_1rw_sync_mask_write_byte.sv
// Single-port synchronous RAM with per-byte write mask. The read data register
// holds its value until the next read, so callers can stall without re-reading.
module bsg_mem_1rw_sync_mask_write_byte #(
  parameter int width_p = 64,
  parameter int els_p   = 1024,
  localparam int addr_width_lp = $clog2(els_p),
  localparam int mask_width_lp = width_p / 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     v_i,
  input  logic                     w_i,
  input  logic [addr_width_lp-1:0] addr_i,
  input  logic [width_p-1:0]       data_i,
  input  logic [mask_width_lp-1:0] write_mask_i,
  output logic [width_p-1:0]       data_o
);

  logic [width_p-1:0] mem_q [els_p];
  logic [width_p-1:0] data_q;

  always_ff @(posedge clk_i) begin
    if (v_i & w_i) begin
      for (int b = 0; b < mask_width_lp; b++) begin
        if (write_mask_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= data_i[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      data_q <= '0;
    end else if (v_i & ~w_i) begin
      data_q <= mem_q[addr_i];
    end else begin
      data_q <= data_q;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/bp_me_burst_mem_responder.sv
// Memory-side BedRock burst endpoint: one command in flight, critical-word-first reads,
// byte-masked writes. Optional zero-init sweep via BP_ME_BURST_MEM_RESPONDER_ZERO_INIT_EN.
module bp_me_burst_mem_responder
  import bp_me_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_default_cfg,
  parameter int         mem_els_p   = 1024
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic [cce_mem_msg_header_width_gp-1:0] mem_cmd_header_i,
  input  logic                                   mem_cmd_header_v_i,
  output logic                                   mem_cmd_header_ready_and_o,
  input  logic [63:0]                            mem_cmd_data_i,
  input  logic                                   mem_cmd_data_v_i,
  output logic                                   mem_cmd_data_ready_and_o,
  output logic [cce_mem_msg_header_width_gp-1:0] mem_resp_header_o,
  output logic                                   mem_resp_header_v_o,
  input  logic                                   mem_resp_header_ready_and_i,
  output logic [63:0]                            mem_resp_data_o,
  output logic                                   mem_resp_data_v_o,
  input  logic                                   mem_resp_data_ready_and_i
);

  localparam bp_proc_param_s cfg_lp = bp_get_params(bp_params_p);
  localparam int dword_width_lp = cfg_lp.dword_width;
  localparam int lg_els_lp      = $clog2(mem_els_p);

  bp_me_burst_mem_resp_state_e state_q, state_d;
  bp_bedrock_cce_mem_header_s  hdr_q, hdr_d, cmd_hdr_s;
  logic [3:0]                  beat_q, beat_d, src_beat_s;
  logic [4:0]                  n_beats_s, src_beats_s;
  logic                        last_beat_s;
  logic [2:0]                  src_size_s;
  logic [lg_els_lp-1:0]        src_base_s, wrap_mask_s, idx_s, ram_addr_s;
  logic                        ram_v_s, ram_w_s;
  logic [dword_width_lp-1:0]   ram_wdata_s, ram_rdata_s;
  logic [7:0]                  ram_mask_s;
  logic                        cmd_hdr_hs_s, cmd_data_hs_s, resp_hdr_hs_s, resp_data_hs_s;

  assign cmd_hdr_s   = bp_bedrock_cce_mem_header_s'(mem_cmd_header_i);
  assign n_beats_s   = bp_me_burst_beats(hdr_q.size, dword_width_lp);
  assign last_beat_s = ({1'b0, beat_q} == (n_beats_s - 5'd1));

  assign mem_cmd_header_ready_and_o = ~reset_i & (state_q == e_ready);
  assign mem_cmd_data_ready_and_o   = ~reset_i & (state_q == e_write);
  assign mem_resp_header_v_o        = ~reset_i & ((state_q == e_write_hdr) | (state_q == e_read_hdr));
  assign mem_resp_data_v_o          = ~reset_i & (state_q == e_read_data);
  assign mem_resp_header_o          = hdr_q;
  assign mem_resp_data_o            = ram_rdata_s;

  assign cmd_hdr_hs_s   = mem_cmd_header_v_i & mem_cmd_header_ready_and_o;
  assign cmd_data_hs_s  = mem_cmd_data_v_i & mem_cmd_data_ready_and_o;
  assign resp_hdr_hs_s  = mem_resp_header_v_o & mem_resp_header_ready_and_i;
  assign resp_data_hs_s = mem_resp_data_v_o & mem_resp_data_ready_and_i;

  // The first read beat is issued straight from the incoming header; read_data looks one beat ahead.
  assign src_base_s = (state_q == e_ready) ? cmd_hdr_s.addr[3 +: lg_els_lp] : hdr_q.addr[3 +: lg_els_lp];
  assign src_size_s = (state_q == e_ready) ? cmd_hdr_s.size : hdr_q.size;
  assign src_beat_s = (state_q == e_ready)     ? 4'd0 :
                      (state_q == e_read_data) ? (beat_q + 4'd1) : beat_q;

  // Critical-word-first: only the low log2(N) index bits advance, wrapping inside the block.
  always_comb begin
    src_beats_s = bp_me_burst_beats(src_size_s, dword_width_lp);
    wrap_mask_s = lg_els_lp'(src_beats_s - 5'd1);
    idx_s = (src_base_s & ~wrap_mask_s)
          | ((src_base_s + lg_els_lp'(src_beat_s)) & wrap_mask_s);
  end

`ifdef BP_ME_BURST_MEM_RESPONDER_ZERO_INIT_EN
  logic [lg_els_lp-1:0] init_cnt_q, init_cnt_d;
  assign ram_addr_s = (state_q == e_reset) ? init_cnt_q : idx_s;
`else
  assign ram_addr_s = idx_s;
`endif

  always_comb begin
    state_d     = state_q;
    hdr_d       = hdr_q;
    beat_d      = beat_q;
    ram_v_s     = 1'b0;
    ram_w_s     = 1'b0;
    ram_wdata_s = mem_cmd_data_i;
    ram_mask_s  = 8'h00;
`ifdef BP_ME_BURST_MEM_RESPONDER_ZERO_INIT_EN
    init_cnt_d  = init_cnt_q;
`endif
    case (state_q)
`ifdef BP_ME_BURST_MEM_RESPONDER_ZERO_INIT_EN
      e_reset: begin
        ram_v_s     = 1'b1;
        ram_w_s     = 1'b1;
        ram_wdata_s = '0;
        ram_mask_s  = 8'hFF;
        init_cnt_d  = init_cnt_q + lg_els_lp'(1);
        if (init_cnt_q == lg_els_lp'(mem_els_p - 1)) begin
          state_d = e_ready;
        end else begin
          state_d = e_reset;
        end
      end
`endif
      e_ready: begin
        if (cmd_hdr_hs_s) begin
          hdr_d  = cmd_hdr_s;
          beat_d = 4'd0;
          if (bp_me_is_read(cmd_hdr_s.msg_type)) begin
            ram_v_s = 1'b1;
            state_d = e_read_hdr;
          end else begin
            state_d = e_write;
          end
        end else begin
          state_d = e_ready;
        end
      end
      e_write: begin
        if (cmd_data_hs_s) begin
          // Unsupported message types consume their beats without touching the RAM.
          ram_v_s    = bp_me_is_write(hdr_q.msg_type);
          ram_w_s    = 1'b1;
          ram_mask_s = bp_me_byte_mask(hdr_q.size, hdr_q.addr[2:0]);
          if (last_beat_s) begin
            beat_d  = 4'd0;
            state_d = e_write_hdr;
          end else begin
            beat_d  = beat_q + 4'd1;
          end
        end else begin
          state_d = e_write;
        end
      end
      e_write_hdr: begin
        if (resp_hdr_hs_s) begin
          state_d = e_ready;
        end else begin
          state_d = e_write_hdr;
        end
      end
      e_read_hdr: begin
        if (resp_hdr_hs_s) begin
          state_d = e_read_data;
        end else begin
          state_d = e_read_hdr;
        end
      end
      e_read_data: begin
        if (resp_data_hs_s) begin
          if (last_beat_s) begin
            beat_d  = 4'd0;
            state_d = e_ready;
          end else begin
            ram_v_s = 1'b1;
            beat_d  = beat_q + 4'd1;
          end
        end else begin
          state_d = e_read_data;
        end
      end
      default: begin
        state_d = e_ready;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
`ifdef BP_ME_BURST_MEM_RESPONDER_ZERO_INIT_EN
      state_q    <= e_reset;
      init_cnt_q <= '0;
`else
      state_q    <= e_ready;
`endif
      hdr_q      <= '0;
      beat_q     <= 4'd0;
    end else begin
`ifdef BP_ME_BURST_MEM_RESPONDER_ZERO_INIT_EN
      init_cnt_q <= init_cnt_d;
`endif
      state_q    <= state_d;
      hdr_q      <= hdr_d;
      beat_q     <= beat_d;
    end
  end

  bsg_mem_1rw_sync_mask_write_byte #(
    .width_p (dword_width_lp),
    .els_p   (mem_els_p)
  ) mem (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .v_i          (ram_v_s),
    .w_i          (ram_w_s),
    .addr_i       (ram_addr_s),
    .data_i       (ram_wdata_s),
    .write_mask_i (ram_mask_s),
    .data_o       (ram_rdata_s)
  );

endmodule

// File: tb/tb_bp_me_burst_mem_responder.sv
// Directed self-checking bench for bp_me_burst_mem_responder (optionally with
// BP_ME_BURST_MEM_RESPONDER_ZERO_INIT_EN defined).
module tb_bp_me_burst_mem_responder;
  import bp_me_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                                   reset_i;
  logic [cce_mem_msg_header_width_gp-1:0] cmd_hdr;
  logic                                   cmd_hdr_v, cmd_hdr_ready;
  logic [63:0]                            cmd_data;
  logic                                   cmd_data_v, cmd_data_ready;
  logic [cce_mem_msg_header_width_gp-1:0] resp_hdr;
  logic                                   resp_hdr_v, resp_hdr_ready;
  logic [63:0]                            resp_data;
  logic                                   resp_data_v, resp_data_ready;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_beats [8];

  bp_me_burst_mem_responder #(.bp_params_p(e_bp_default_cfg), .mem_els_p(1024)) dut (
    .clk_i                       (clk),
    .reset_i                     (reset_i),
    .mem_cmd_header_i            (cmd_hdr),
    .mem_cmd_header_v_i          (cmd_hdr_v),
    .mem_cmd_header_ready_and_o  (cmd_hdr_ready),
    .mem_cmd_data_i              (cmd_data),
    .mem_cmd_data_v_i            (cmd_data_v),
    .mem_cmd_data_ready_and_o    (cmd_data_ready),
    .mem_resp_header_o           (resp_hdr),
    .mem_resp_header_v_o         (resp_hdr_v),
    .mem_resp_header_ready_and_i (resp_hdr_ready),
    .mem_resp_data_o             (resp_data),
    .mem_resp_data_v_o           (resp_data_v),
    .mem_resp_data_ready_and_i   (resp_data_ready)
  );

  function automatic bp_bedrock_cce_mem_header_s make_hdr(input bp_bedrock_mem_type_e t,
      input logic [39:0] a, input bp_bedrock_msg_size_e s);
    bp_bedrock_cce_mem_header_s h;
    h.msg_type       = t;
    h.addr           = a;
    h.size           = s;
    h.payload.lce_id = 8'h5A;
    h.payload.way_id = 3'd2;
    return h;
  endfunction

  // Both transaction tasks start and end aligned just after a falling edge.
  task automatic issue_write(input string name, input bp_bedrock_cce_mem_header_s h,
      input int nb, input logic [63:0] d0, input logic [63:0] step);
    n_checks++;
    if (cmd_hdr_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s hdr_ready: got %b expected 1", name, cmd_hdr_ready);
    end
    cmd_hdr = h; cmd_hdr_v = 1'b1;
    @(negedge clk); cmd_hdr_v = 1'b0;
    for (int k = 0; k < nb; k++) begin
      n_checks++;
      if (cmd_data_ready !== 1'b1) begin
        n_fail++; $display("FAIL %s data_ready beat %0d: got %b expected 1", name, k, cmd_data_ready);
      end
      cmd_data = d0 + 64'(k) * step; cmd_data_v = 1'b1;
      @(negedge clk);
    end
    cmd_data_v = 1'b0;
    n_checks++;
    if ({resp_hdr_v, resp_data_v, resp_hdr} !== {1'b1, 1'b0, h}) begin
      n_fail++; $display("FAIL %s resp_hdr: got v=%b dv=%b %h expected v=1 dv=0 %h",
                         name, resp_hdr_v, resp_data_v, resp_hdr, h);
    end
    @(negedge clk);
    n_checks++;
    if ({cmd_hdr_ready, resp_hdr_v} !== 2'b10) begin
      n_fail++; $display("FAIL %s post ready/valid: got %b%b expected 10", name, cmd_hdr_ready, resp_hdr_v);
    end
  endtask

  task automatic issue_read(input string name, input bp_bedrock_cce_mem_header_s h,
      input int nb, input int stall_beat);
    n_checks++;
    if (cmd_hdr_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s hdr_ready: got %b expected 1", name, cmd_hdr_ready);
    end
    cmd_hdr = h; cmd_hdr_v = 1'b1;
    @(negedge clk); cmd_hdr_v = 1'b0;
    n_checks++;
    if ({resp_hdr_v, resp_data_v, cmd_data_ready, resp_hdr} !== {3'b100, h}) begin
      n_fail++; $display("FAIL %s resp_hdr: got v=%b dv=%b dr=%b %h expected 100 %h",
                         name, resp_hdr_v, resp_data_v, cmd_data_ready, resp_hdr, h);
    end
    @(negedge clk);
    for (int k = 0; k < nb; k++) begin
      n_checks++;
      if ({resp_data_v, resp_data} !== {1'b1, exp_beats[k]}) begin
        n_fail++; $display("FAIL %s beat %0d: got v=%b %h expected v=1 %h",
                           name, k, resp_data_v, resp_data, exp_beats[k]);
      end
      if (k == stall_beat) begin
        resp_data_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          n_checks++;
          if ({resp_data_v, resp_data} !== {1'b1, exp_beats[k]}) begin
            n_fail++; $display("FAIL %s stall %0d beat %0d: got v=%b %h expected v=1 %h",
                               name, s, k, resp_data_v, resp_data, exp_beats[k]);
          end
        end
        resp_data_ready = 1'b1;
      end
      @(negedge clk);
    end
    n_checks++;
    if ({resp_data_v, cmd_hdr_ready} !== 2'b01) begin
      n_fail++; $display("FAIL %s end: got dv=%b ready=%b expected dv=0 ready=1", name, resp_data_v, cmd_hdr_ready);
    end
  endtask

  task automatic wait_hdr_ready(output int cycles);
    cycles = 0;
    while (cmd_hdr_ready !== 1'b1 && cycles < 2000) begin
      cycles++;
      @(negedge clk); #1;
    end
  endtask

  task automatic test_reset();
    int cycles;
    reset_i = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({cmd_hdr_ready, cmd_data_ready, resp_hdr_v, resp_data_v} !== 4'b0000) begin
      n_fail++; $display("FAIL reset handshakes: got %b%b%b%b expected 0000",
                         cmd_hdr_ready, cmd_data_ready, resp_hdr_v, resp_data_v);
    end
    n_checks++;
    if ({resp_hdr, resp_data} !== '0) begin
      n_fail++; $display("FAIL reset outputs: got %h %h expected 0", resp_hdr, resp_data);
    end
    reset_i = 1'b0; #1;
`ifdef BP_ME_BURST_MEM_RESPONDER_ZERO_INIT_EN
    wait_hdr_ready(cycles);
    n_checks++;
    if (cycles != 1024) begin
      n_fail++; $display("FAIL zero_init ready delay: got %0d expected 1024", cycles);
    end
    for (int k = 0; k < 8; k++) exp_beats[k] = 64'h0;
    issue_read("zero_init_rd", make_hdr(e_bedrock_mem_rd, 40'h00_8000_1000, e_bedrock_msg_size_64), 8, -1);
`else
    cycles = 0;
    n_checks++;
    if (cmd_hdr_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset release hdr_ready: got %b expected 1 (%0d)", cmd_hdr_ready, cycles);
    end
`endif
  endtask

  task automatic test_write_read();
    issue_write("wr64", make_hdr(e_bedrock_mem_wr, 40'h00_8000_0040, e_bedrock_msg_size_64), 8, 64'h0, 64'h1);
    for (int k = 0; k < 8; k++) exp_beats[k] = 64'(k);
    issue_read("rd64", make_hdr(e_bedrock_mem_rd, 40'h00_8000_0040, e_bedrock_msg_size_64), 8, -1);
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 8; k++) exp_beats[k] = 64'((k + 3) % 8);
    issue_read("wrap", make_hdr(e_bedrock_mem_rd, 40'h00_8000_0058, e_bedrock_msg_size_64), 8, -1);
  endtask

  task automatic test_byte_write();
    issue_write("fill8", make_hdr(e_bedrock_mem_wr, 40'h00_8000_0000, e_bedrock_msg_size_8),
                1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
    issue_write("uc_wr1", make_hdr(e_bedrock_mem_uc_wr, 40'h00_8000_0003, e_bedrock_msg_size_1),
                1, 64'h0000_0000_AB00_0000, 64'h0);
    exp_beats[0] = 64'hFFFF_FFFF_ABFF_FFFF;
    issue_read("uc_rd8", make_hdr(e_bedrock_mem_uc_rd, 40'h00_8000_0000, e_bedrock_msg_size_8), 1, -1);
    issue_read("uc_rd1", make_hdr(e_bedrock_mem_uc_rd, 40'h00_8000_0003, e_bedrock_msg_size_1), 1, -1);
  endtask

  task automatic test_discard();
    issue_write("pre", make_hdr(e_bedrock_mem_pre, 40'h00_8000_0000, e_bedrock_msg_size_8),
                1, 64'h0000_0000_0000_1234, 64'h0);
    exp_beats[0] = 64'hFFFF_FFFF_ABFF_FFFF;
    issue_read("pre_rd", make_hdr(e_bedrock_mem_uc_rd, 40'h00_8000_0000, e_bedrock_msg_size_8), 1, -1);
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < 8; k++) exp_beats[k] = 64'(k);
    issue_read("bp", make_hdr(e_bedrock_mem_rd, 40'h00_8000_0040, e_bedrock_msg_size_64), 8, 2);
  endtask

  task automatic test_reset_mid_read();
    int cycles;
    cmd_hdr = make_hdr(e_bedrock_mem_rd, 40'h00_8000_0040, e_bedrock_msg_size_64);
    cmd_hdr_v = 1'b1;
    @(negedge clk); cmd_hdr_v = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({resp_data_v, resp_data} !== {1'b1, 64'h1}) begin
      n_fail++; $display("FAIL rst_mid beat1: got v=%b %h expected v=1 1", resp_data_v, resp_data);
    end
    @(negedge clk);
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0; #1;
    n_checks++;
    if ({resp_hdr_v, resp_data_v, cmd_data_ready, resp_hdr, resp_data} !== '0) begin
      n_fail++; $display("FAIL rst_mid outputs: got %b%b%b %h %h expected all 0",
                         resp_hdr_v, resp_data_v, cmd_data_ready, resp_hdr, resp_data);
    end
    wait_hdr_ready(cycles);
    n_checks++;
    if (cmd_hdr_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid ready timeout: got %b after %0d cycles expected 1", cmd_hdr_ready, cycles);
    end
    for (int k = 0; k < 8; k++) exp_beats[k] = 64'((k + 3) % 8);
    issue_read("rst_mid_new", make_hdr(e_bedrock_mem_rd, 40'h00_8000_0058, e_bedrock_msg_size_64), 8, -1);
  endtask

  initial begin
    reset_i = 1'b1; cmd_hdr = '0; cmd_hdr_v = 1'b0; cmd_data = 64'h0; cmd_data_v = 1'b0;
    resp_hdr_ready = 1'b1; resp_data_ready = 1'b1;
    test_reset();
    test_write_read();
    test_wrap();
    test_byte_write();
    test_discard();
    test_backpressure();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
